uart_rx: RTL and testbench

//  UART receiver: the receive end of the serial link whose transmit side runs off the baud_tick generator.

---
 rtl/uart_rx_if.sv | 42 ++++
 rtl/uart_rx.sv | 194 +++++++++++++++++++
 tb/tb_uart_rx.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_if
//  Purpose  : Consumer-side bundle of the UART receiver: received byte with
//             valid/ready handshake, error pulses and the busy indicator.
//  Signals  : rx_data   [7:0] received byte, stable while rx_valid=1
//             rx_valid        byte available, held until accepted
//             rx_ready        consumer accepts on rx_valid & rx_ready
//             frame_err       one-cycle pulse, stop bit sampled low
//             overrun         one-cycle pulse, good byte lost (holding full)
//             busy            receiver not idle
//  Modports : master - the receiver (drives data/status, reads ready)
//             slave  - the consumer (reads data/status, drives ready)
//  Revision : 1.0  initial release
// ============================================================================
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  modport master (
    output rx_data,
    output rx_valid,
    output frame_err,
    output overrun,
    output busy,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  overrun,
    input  busy,
    output rx_ready
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Purpose  : 8N1 UART receiver (LSB first) with OVERSAMPLE x baud internal
//             tick, two-flop input synchroniser, start-bit validation,
//             valid/ready holding register, framing and overrun flags.
//  Ports    : clk  - system clock, rising edge
//             rst  - asynchronous active-high reset
//             rx   - asynchronous serial input, idles high
//             bus  - uart_rx_if.master (rx_data, rx_valid, rx_ready,
//                    frame_err, overrun, busy)
//  Params   : CLK_FREQ (Hz), BAUD (bit/s), OVERSAMPLE (even, >= 8)
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rx,
  uart_rx_if.master bus
);

  localparam int OS_DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV_W  = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
  localparam int TICK_W = $clog2(OVERSAMPLE);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(OS_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } state_t;

  state_t              state_q,     state_d;
  logic                rx_meta_q,   rx_meta_d;
  logic                rxs_q,       rxs_d;
  logic [DIV_W-1:0]    div_cnt_q,   div_cnt_d;
  logic [TICK_W-1:0]   tick_cnt_q,  tick_cnt_d;
  logic [2:0]          bit_cnt_q,   bit_cnt_d;
  logic [7:0]          shreg_q,     shreg_d;
  logic [7:0]          rx_data_q,   rx_data_d;
  logic                rx_valid_q,  rx_valid_d;
  logic                frame_err_q, frame_err_d;
  logic                overrun_q,   overrun_d;
  logic                busy_q,      busy_d;
  logic                os_tick;

  // Free-running oversample divider; with OS_DIV==1 the tick is every clk.
  assign os_tick = (div_cnt_q == DIV_LAST);

  always_comb begin
    rx_meta_d   = rx;
    rxs_d       = rx_meta_q;
    div_cnt_d   = os_tick ? '0 : div_cnt_q + DIV_W'(1);
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    // Accept; a delivery in the same cycle below overrides this.
    if (rx_valid_q && bus.rx_ready) begin
      rx_valid_d = 1'b0;
    end

    if (os_tick) begin
      case (state_q)
        S_IDLE: begin
          if (!rxs_q) begin
            state_d    = S_START;
            tick_cnt_d = '0;
          end
        end

        S_START: begin
          // Re-check the line half a bit after the falling edge; a high
          // level there means a glitch and the frame is silently dropped.
          if (tick_cnt_q == TICK_HALF) begin
            tick_cnt_d = '0;
            if (!rxs_q) begin
              state_d   = S_DATA;
              bit_cnt_d = 3'd0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_ONE;
          end
        end

        S_DATA: begin
          if (tick_cnt_q == TICK_LAST) begin
            // Line is LSB first, so shifting in at the MSB leaves bit 0
            // in shreg[0] after eight samples.
            shreg_d    = {rxs_q, shreg_q[7:1]};
            tick_cnt_d = '0;
            if (bit_cnt_q == 3'd7) begin
              state_d = S_STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_ONE;
          end
        end

        S_STOP: begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            if (rxs_q) begin
              // Returning to IDLE at the stop-bit centre lets a start bit
              // that follows immediately be caught.
              state_d = S_IDLE;
              if (!rx_valid_q || bus.rx_ready) begin
                rx_data_d  = shreg_q;
                rx_valid_d = 1'b1;
              end else begin
                overrun_d = 1'b1;
              end
            end else begin
              frame_err_d = 1'b1;
              state_d     = S_WAIT_HIGH;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_ONE;
          end
        end

        S_WAIT_HIGH: begin
          // A break or stuck-low line must end before a new start bit counts.
          if (rxs_q) begin
            state_d = S_IDLE;
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rx_meta_q   <= 1'b1;
      rxs_q       <= 1'b1;
      div_cnt_q   <= '0;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= 3'd0;
      shreg_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_meta_q   <= rx_meta_d;
      rxs_q       <= rxs_d;
      div_cnt_q   <= div_cnt_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;
  assign bus.busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx
//  Purpose  : Self-checking bench for uart_rx at 16 clk per bit (OS_DIV=1).
//             Table of frames with hand-written expected outcomes, directed
//             corner sequences, then random frames against a frame-level
//             reference model of the holding register.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx;

  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 100_000;
  localparam int OS       = 16;
  localparam int BIT_CLK  = 16;

  localparam int EV_DATA = 0;
  localparam int EV_FE   = 1;
  localparam int EV_OV   = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       ready;
    int         gap_bits;
    int         exp_kind;
    logic [7:0] exp_data;
  } vec_t;

  logic clk;
  logic rst;
  logic rx;

  uart_rx_if bus_if ();

  uart_rx #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .rx  (rx),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  int   valid_cycles = 0;
  ev_t  ev_q[$];
  ev_t  exp_q[$];
  logic m_hold = 1'b0;
  logic prev_valid = 1'b0;
  logic prev_ready = 1'b0;

  // Observe outputs 1 time unit after each rising edge. A delivery is a
  // valid byte that was not already pending (valid was low, or it was
  // accepted in the previous cycle).
  always @(posedge clk) begin
    #1;
    if (rst) begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end else begin
      if (bus_if.rx_valid && (!prev_valid || prev_ready))
        ev_q.push_back('{kind: EV_DATA, data: bus_if.rx_data});
      if (bus_if.frame_err)
        ev_q.push_back('{kind: EV_FE, data: 8'h00});
      if (bus_if.overrun)
        ev_q.push_back('{kind: EV_OV, data: 8'h00});
      if (bus_if.rx_valid)
        valid_cycles++;
      prev_valid = bus_if.rx_valid;
      prev_ready = bus_if.rx_ready;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input int kind, input logic [7:0] data);
    exp_q.push_back('{kind: kind, data: data});
  endtask

  task automatic check_events(input string name);
    ev_t e;
    ev_t a;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (ev_q.size() == 0) begin
        bad++;
        $display("FAIL %s: no event seen, expected kind=%0d data=0x%02h", name, e.kind, e.data);
      end else begin
        a = ev_q.pop_front();
        if (a.kind != e.kind || (e.kind == EV_DATA && a.data !== e.data)) begin
          bad++;
          $display("FAIL %s: got kind=%0d data=0x%02h, expected kind=%0d data=0x%02h",
                   name, a.kind, a.data, e.kind, e.data);
        end
      end
    end
    total++;
    if (ev_q.size() != 0) begin
      bad++;
      $display("FAIL %s: %0d extra events, first kind=%0d data=0x%02h, expected none",
               name, ev_q.size(), ev_q[0].kind, ev_q[0].data);
      ev_q.delete();
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  task automatic idle_bits(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  // Frame-level reference: what one frame does to the holding register.
  task automatic model_frame(input logic [7:0] d, input logic stop, input logic rdy);
    if (rdy) m_hold = 1'b0;
    if (!stop) begin
      expect_ev(EV_FE, 8'h00);
    end else if (m_hold && !rdy) begin
      expect_ev(EV_OV, 8'h00);
    end else begin
      expect_ev(EV_DATA, d);
      m_hold = !rdy;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rx_data"},   {24'h0, bus_if.rx_data}, 32'h00);
    chk({tag, "_rx_valid"},  {31'h0, bus_if.rx_valid}, 32'h0);
    chk({tag, "_frame_err"}, {31'h0, bus_if.frame_err}, 32'h0);
    chk({tag, "_overrun"},   {31'h0, bus_if.overrun}, 32'h0);
    chk({tag, "_busy"},      {31'h0, bus_if.busy}, 32'h0);
  endtask

  vec_t vecs [8];

  initial begin
    int   vc0;
    logic [7:0] d;
    logic       st;
    logic       rdy;
    int         gap;

    vecs[0] = '{8'hA5, 1'b1, 1'b1, 1, EV_DATA, 8'hA5};
    vecs[1] = '{8'h5A, 1'b1, 1'b1, 0, EV_DATA, 8'h5A};
    vecs[2] = '{8'h3C, 1'b0, 1'b1, 1, EV_FE,   8'h00};
    vecs[3] = '{8'h11, 1'b1, 1'b0, 1, EV_DATA, 8'h11};
    vecs[4] = '{8'h22, 1'b1, 1'b0, 1, EV_OV,   8'h00};
    vecs[5] = '{8'h33, 1'b1, 1'b1, 0, EV_DATA, 8'h33};
    vecs[6] = '{8'h00, 1'b0, 1'b0, 2, EV_FE,   8'h00};
    vecs[7] = '{8'hC3, 1'b1, 1'b1, 1, EV_DATA, 8'hC3};

    rst = 1'b1;
    rx  = 1'b1;
    bus_if.rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    idle_bits(1);

    // Single 0xA5 with consumer ready: exactly one valid cycle.
    bus_if.rx_ready = 1'b1;
    vc0 = valid_cycles;
    send_frame(8'hA5, 1'b1);
    idle_bits(1);
    expect_ev(EV_DATA, 8'hA5);
    check_events("a5_frame");
    chk("a5_valid_width", valid_cycles - vc0, 1);
    chk("a5_data_held", {24'h0, bus_if.rx_data}, 32'hA5);

    // Start-bit glitch: 4 clk low.
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    chk("glitch_busy_in_start", {31'h0, bus_if.busy}, 32'h1);
    repeat (30) @(negedge clk);
    chk("glitch_busy_back", {31'h0, bus_if.busy}, 32'h0);
    chk("glitch_no_valid", {31'h0, bus_if.rx_valid}, 32'h0);
    check_events("glitch");

    // Framing error then a held-low line.
    send_frame(8'h3C, 1'b0);
    repeat (40) @(negedge clk);
    expect_ev(EV_FE, 8'h00);
    check_events("break_frame_err");
    chk("break_busy_wait_high", {31'h0, bus_if.busy}, 32'h1);
    chk("break_no_valid", {31'h0, bus_if.rx_valid}, 32'h0);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    chk("break_busy_released", {31'h0, bus_if.busy}, 32'h0);
    send_frame(8'h55, 1'b1);
    idle_bits(1);
    expect_ev(EV_DATA, 8'h55);
    check_events("after_break_55");

    // Overrun with consumer stalled.
    bus_if.rx_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    idle_bits(1);
    send_frame(8'h22, 1'b1);
    idle_bits(1);
    expect_ev(EV_DATA, 8'h11);
    expect_ev(EV_OV, 8'h00);
    check_events("overrun_seq");
    chk("overrun_data_held", {24'h0, bus_if.rx_data}, 32'h11);
    chk("overrun_valid_held", {31'h0, bus_if.rx_valid}, 32'h1);
    bus_if.rx_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("accept_valid_falls", {31'h0, bus_if.rx_valid}, 32'h0);
    send_frame(8'h33, 1'b1);
    idle_bits(1);
    expect_ev(EV_DATA, 8'h33);
    check_events("after_overrun_33");

    // Reset in the middle of the data bits of 0xFF.
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("midframe_rst");
    rst = 1'b0;
    repeat (20) @(negedge clk);
    send_frame(8'h81, 1'b1);
    idle_bits(1);
    expect_ev(EV_DATA, 8'h81);
    check_events("after_rst_81");

    // Back-to-back frames, no idle gap.
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h80, 1'b1);
    idle_bits(1);
    expect_ev(EV_DATA, 8'h00);
    expect_ev(EV_DATA, 8'hFF);
    expect_ev(EV_DATA, 8'h80);
    check_events("back_to_back");

    // Table of frames with hand-derived outcomes.
    for (int i = 0; i < 8; i++) begin
      bus_if.rx_ready = vecs[i].ready;
      send_frame(vecs[i].data, vecs[i].stop);
      idle_bits(vecs[i].gap_bits);
      expect_ev(vecs[i].exp_kind, vecs[i].exp_data);
      check_events($sformatf("vec%0d", i));
    end

    // Random frames against the reference model.
    bus_if.rx_ready = 1'b1;
    idle_bits(1);
    m_hold = 1'b0;
    for (int i = 0; i < 24; i++) begin
      d   = 8'($urandom_range(0, 255));
      st  = ($urandom_range(0, 4) != 0);
      rdy = 1'($urandom_range(0, 1));
      gap = st ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
      bus_if.rx_ready = rdy;
      model_frame(d, st, rdy);
      send_frame(d, st);
      idle_bits(gap);
      check_events($sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
